// File: rtl/multipler_pkg.sv
// rtl/multipler_pkg.sv - shared types and sizes for the multiplier result streamer
package multipler_pkg;

    localparam int MUL_DATA_LENGTH  = 64;
    localparam int MUL_BLOCK_LENGTH = 16;
    localparam int NUM_OUT_WORDS    = 2 * MUL_DATA_LENGTH / MUL_BLOCK_LENGTH;

    typedef logic [$clog2(NUM_OUT_WORDS)-1:0] out_idx_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

endpackage

// File: rtl/multipler_result_buf2.sv
// rtl/multipler_result_buf2.sv - two-slot ping-pong product buffer with occupancy tracking
module multipler_result_buf2 #(
    parameter int WIDTH = 128
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             push_ok_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wp_q;
    logic             rp_q;
    logic [1:0]       cnt_q;
    logic             pop_ok;

    // A pop in the same cycle frees a slot, so a push into a full buffer is still accepted.
    assign pop_ok    = pop_i & (cnt_q != 2'd0);
    assign push_ok_o = push_i & ((cnt_q != 2'd2) | pop_ok);
    assign full_o    = (cnt_q == 2'd2);
    assign empty_o   = (cnt_q == 2'd0);
    assign rdata_o   = slot_q[rp_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push_ok_o) begin
                slot_q[wp_q] <= push_data_i;
                wp_q         <= ~wp_q;
            end
            if (pop_ok) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + 2'(push_ok_o) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/multipler_result_streamer.sv
// rtl/multipler_result_streamer.sv - buffers multiplier products and streams them LSB-first as words
module multipler_result_streamer
    import multipler_pkg::*;
#(
    parameter int DATA_LENGTH  = MUL_DATA_LENGTH,
    parameter int BLOCK_LENGTH = MUL_BLOCK_LENGTH,
    localparam int NUM_WORDS   = 2 * DATA_LENGTH / BLOCK_LENGTH,
    localparam int IDX_W       = $clog2(NUM_WORDS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     mul_finish_i,
    input  logic [2*DATA_LENGTH-1:0] mul_result_i,
    output logic                     full_o,
    output logic                     overflow_o,
    input  logic                     clr_ovf_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [BLOCK_LENGTH-1:0]  out_data_o,
    output logic [IDX_W-1:0]         out_idx_o,
    output logic                     out_last_o
);

    stream_state_t            state_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     ovf_q;
    logic                     push_ok;
    logic                     buf_full;
    logic                     buf_empty;
    logic [2*DATA_LENGTH-1:0] rdata;
    logic                     transfer;
    logic                     last_word;
    logic                     pop;

    assign transfer  = (state_q == STREAM) & out_ready_i;
    assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));
    assign pop       = transfer & last_word;

    multipler_result_buf2 #(
        .WIDTH (2 * DATA_LENGTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (mul_finish_i),
        .push_data_i (mul_result_i),
        .pop_i       (pop),
        .push_ok_o   (push_ok),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .rdata_o     (rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push_ok || !buf_empty) begin
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        if (last_word) begin
                            idx_q <= '0;
                            // Keep valid high when the other slot holds, or is receiving, a product.
                            if (!(buf_full || push_ok)) begin
                                state_q <= IDLE;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (mul_finish_i && !push_ok) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf_i) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign full_o      = buf_full;
    assign overflow_o  = ovf_q;
    assign out_valid_o = (state_q == STREAM);
    assign out_data_o  = out_valid_o ? rdata[BLOCK_LENGTH*idx_q +: BLOCK_LENGTH] : '0;
    assign out_idx_o   = idx_q;
    assign out_last_o  = out_valid_o & last_word;

endmodule
